// File: rtl/rvlab_clk_rst_seq_if.sv
// Sideband bundle between the clock/reset sequencer and its neighbours:
// the MMCM (RST in, LOCKED out) and the system reset consumer.
interface rvlab_clk_rst_seq_if #(
   parameter int unsigned RETRY_W = 2
);
   logic               locked_i;
   logic               soft_rst_req_i;
   logic               mmcm_rst_o;
   logic               sys_rst_req_o;
   logic               ready_o;
   logic               fail_o;
   logic [RETRY_W-1:0] retry_cnt_o;
   logic [2:0]         state_o;

   // Sequencer side: consumes lock / soft requests, produces resets and status.
   modport slave (
      input  locked_i,
      input  soft_rst_req_i,
      output mmcm_rst_o,
      output sys_rst_req_o,
      output ready_o,
      output fail_o,
      output retry_cnt_o,
      output state_o
   );

   // Environment side: the clock manager and system that surround the sequencer.
   modport master (
      output locked_i,
      output soft_rst_req_i,
      input  mmcm_rst_o,
      input  sys_rst_req_o,
      input  ready_o,
      input  fail_o,
      input  retry_cnt_o,
      input  state_o
   );
endinterface

// File: rtl/rvlab_clk_rst_seq.sv
// Power-up and recovery sequencer for the system MMCM and the system reset.
// Runs on the free-running buffered 100 MHz clock so it keeps working while
// the generated system clock is gated or unlocked. It pulses MMCM RST, waits
// for LOCKED with a timeout and bounded retries, debounces lock, then holds
// the system reset request for a fixed time before declaring the system ready.
module rvlab_clk_rst_seq #(
   parameter int unsigned MMCM_RST_CYCLES     = 16,
   parameter int unsigned LOCK_TIMEOUT_CYCLES = 100000,
   parameter int unsigned LOCK_FILTER_CYCLES  = 8,
   parameter int unsigned RST_HOLD_CYCLES     = 64,
   parameter int unsigned MAX_RETRIES         = 3
) (
   input  logic               clk_100mhz_i,
   input  logic               rst_i,
   rvlab_clk_rst_seq_if.slave bus
);

   // Larger of two parameter values, used to size the shared cycle counter.
   function automatic int unsigned max2(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   // The counter only has to reach the largest terminal count minus one, and
   // every terminal count forces a transition, so it can never wrap.
   localparam int unsigned MAX_CNT = max2(max2(MMCM_RST_CYCLES, LOCK_TIMEOUT_CYCLES),
                                          max2(LOCK_FILTER_CYCLES, RST_HOLD_CYCLES));
   localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);
   localparam int unsigned RETRY_W = $clog2(MAX_RETRIES + 1);

   localparam logic [CNT_W-1:0]   CNT_ZERO     = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]   CNT_ONE      = CNT_W'(1);
   localparam logic [CNT_W-1:0]   MMCM_LAST    = CNT_W'(MMCM_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0]   FILTER_LAST  = CNT_W'(LOCK_FILTER_CYCLES - 1);
   localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_ZERO   = {RETRY_W{1'b0}};
   localparam logic [RETRY_W-1:0] RETRY_ONE    = RETRY_W'(1);
   localparam logic [RETRY_W-1:0] RETRY_LAST   = RETRY_W'(MAX_RETRIES);

   // Encoding is visible on state_o, so values are pinned explicitly.
   typedef enum logic [2:0] {
      S_MMCM_RST    = 3'd0,
      S_WAIT_LOCK   = 3'd1,
      S_LOCK_FILTER = 3'd2,
      S_RST_HOLD    = 3'd3,
      S_RUN         = 3'd4,
      S_FAIL        = 3'd5
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_nxt;
   logic [RETRY_W-1:0] retry;
   logic [RETRY_W-1:0] retry_nxt;
   logic               lock_meta;
   logic               lock_s;
   logic               mmcm_rst;
   logic               sys_rst_req;
   logic               ready;
   logic               fail;

   // Two-flop synchronizer for the asynchronous MMCM LOCKED signal.
   always_ff @(posedge clk_100mhz_i) begin
      if (rst_i) begin
         lock_meta <= 1'b0;
         lock_s    <= 1'b0;
      end else begin
         lock_meta <= bus.locked_i;
         lock_s    <= lock_meta;
      end
   end

   // Transition decisions; cnt restarts from zero on every state change.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      retry_nxt = retry;
      case (state)
         S_MMCM_RST: begin
            if (cnt == MMCM_LAST) begin
               state_nxt = S_WAIT_LOCK;
               cnt_nxt   = CNT_ZERO;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         S_WAIT_LOCK: begin
            // Lock is checked first so it wins over a coincident timeout.
            if (lock_s) begin
               state_nxt = S_LOCK_FILTER;
               cnt_nxt   = CNT_ZERO;
            end else if (cnt == TIMEOUT_LAST) begin
               cnt_nxt = CNT_ZERO;
               if (retry == RETRY_LAST) begin
                  state_nxt = S_FAIL;
               end else begin
                  state_nxt = S_MMCM_RST;
                  retry_nxt = retry + RETRY_ONE;
               end
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         S_LOCK_FILTER: begin
            // A dropout restarts the lock wait with a fresh timeout, same retry.
            if (!lock_s) begin
               state_nxt = S_WAIT_LOCK;
               cnt_nxt   = CNT_ZERO;
            end else if (cnt == FILTER_LAST) begin
               state_nxt = S_RST_HOLD;
               cnt_nxt   = CNT_ZERO;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         S_RST_HOLD: begin
            if (!lock_s) begin
               state_nxt = S_WAIT_LOCK;
               cnt_nxt   = CNT_ZERO;
            end else if (cnt == HOLD_LAST) begin
               state_nxt = S_RUN;
               cnt_nxt   = CNT_ZERO;
               retry_nxt = RETRY_ZERO;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         S_RUN: begin
            // Counter parks at zero here; lock loss outranks a soft request.
            cnt_nxt   = CNT_ZERO;
            retry_nxt = RETRY_ZERO;
            if (!lock_s) begin
               state_nxt = S_MMCM_RST;
            end else if (bus.soft_rst_req_i) begin
               state_nxt = S_RST_HOLD;
            end else begin
               state_nxt = S_RUN;
            end
         end
         S_FAIL: begin
            // Terminal until rst_i; the counter parks so it cannot wrap.
            state_nxt = S_FAIL;
            cnt_nxt   = CNT_ZERO;
         end
         default: begin
            state_nxt = S_MMCM_RST;
            cnt_nxt   = CNT_ZERO;
            retry_nxt = RETRY_ZERO;
         end
      endcase
   end

   // FSM registers plus outputs decoded from the state being entered, so each
   // output changes on the same edge as the state it belongs to.
   always_ff @(posedge clk_100mhz_i) begin
      if (rst_i) begin
         state       <= S_MMCM_RST;
         cnt         <= CNT_ZERO;
         retry       <= RETRY_ZERO;
         mmcm_rst    <= 1'b1;
         sys_rst_req <= 1'b1;
         ready       <= 1'b0;
         fail        <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         retry       <= retry_nxt;
         mmcm_rst    <= (state_nxt == S_MMCM_RST);
         sys_rst_req <= (state_nxt != S_RUN);
         ready       <= (state_nxt == S_RUN);
         fail        <= (state_nxt == S_FAIL);
      end
   end

   assign bus.mmcm_rst_o    = mmcm_rst;
   assign bus.sys_rst_req_o = sys_rst_req;
   assign bus.ready_o       = ready;
   assign bus.fail_o        = fail;
   assign bus.retry_cnt_o   = retry;
   assign bus.state_o       = state;

endmodule

// File: tb/tb_rvlab_clk_rst_seq.sv
// Bench for the clock/reset sequencer. Stimulus computes, from the timing
// rules of the sequencer, the edge at which each state change must appear and
// queues it; a monitor compares every observed output change with the queue.
module tb_rvlab_clk_rst_seq;
   localparam int M  = 4;    // MMCM reset cycles
   localparam int T  = 20;   // lock timeout cycles
   localparam int LF = 3;    // lock filter cycles
   localparam int RH = 5;    // reset hold cycles
   localparam int MR = 2;    // max retries
   localparam int RW = $clog2(MR + 1);
   localparam int NO  = -1;
   localparam int INF = 32'h3fffffff;

   localparam logic [2:0] S_MMCM = 3'd0, S_WAIT = 3'd1, S_FILT = 3'd2,
                          S_HOLD = 3'd3, S_RUN = 3'd4, S_FAIL = 3'd5;

   typedef struct packed {
      int         cyc;
      logic [2:0] st;
      logic [RW-1:0] rt;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   m_retry = 0;
   ev_t  q[$];
   logic [2:0] last_st;
   int   last_rt;
   logic [RW+6:0] act;

   rvlab_clk_rst_seq_if #(.RETRY_W(RW)) bus ();

   rvlab_clk_rst_seq #(
      .MMCM_RST_CYCLES(M), .LOCK_TIMEOUT_CYCLES(T), .LOCK_FILTER_CYCLES(LF),
      .RST_HOLD_CYCLES(RH), .MAX_RETRIES(MR)
   ) dut (
      .clk_100mhz_i(clk),
      .rst_i(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign act = {bus.state_o, bus.mmcm_rst_o, bus.sys_rst_req_o, bus.ready_o,
                 bus.fail_o, bus.retry_cnt_o};

   // Output pattern each state must present: {mmcm_rst, sys_rst_req, ready, fail}.
   function automatic logic [3:0] outs_of(input logic [2:0] st);
      case (st)
         S_MMCM:                 return 4'b1100;
         S_WAIT, S_FILT, S_HOLD: return 4'b0100;
         S_RUN:                  return 4'b0010;
         S_FAIL:                 return 4'b0101;
         default:                return 4'bxxxx;
      endcase
   endfunction

   function automatic logic [RW+6:0] exp_tuple(input logic [2:0] st, input int rt);
      return {st, outs_of(st), rt[RW-1:0]};
   endfunction

   // Queue an expected state entry at edge c (skipped when nothing would change).
   task automatic push(input int c, input logic [2:0] st, input int rt);
      ev_t e;
      if (st == last_st && rt == last_rt) return;
      e.cyc = c;
      e.st  = st;
      e.rt  = rt[RW-1:0];
      q.push_back(e);
      last_st = st;
      last_rt = rt;
   endtask

   // Drive the inputs sampled at the next edge, then move to the next negedge.
   task automatic step(input logic lk, input logic sf);
      bus.locked_i       = lk;
      bus.soft_rst_req_i = sf;
      @(negedge clk);
   endtask

   // Drive edges up to until_edge: lock high on [on, off), soft on edges a and b.
   task automatic drive(input int until_edge, input int on, input int off,
                        input int sa, input int sb);
      while (cyc < until_edge) begin
         step((cyc + 1 >= on) && (cyc + 1 < off), (cyc + 1 == sa) || (cyc + 1 == sb));
      end
   endtask

   // Assert rst_i for the next edge r; the block must show reset values at r.
   task automatic do_reset(output int r);
      rst = 1'b1;
      bus.locked_i = 1'b0;
      bus.soft_rst_req_i = 1'b0;
      r = cyc + 1;
      m_retry = 0;
      push(r, S_MMCM, 0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Expected climb to RUN for a lock first sampled high at edge e and held,
   // while the lock wait was entered at edge w (lock seen 2 edges after e,
   // but not before the first edge spent waiting).
   task automatic exp_climb(input int w, input int e, input bit to_run, output int run_edge);
      int f;
      f = (e + 2 > w + 1) ? e + 2 : w + 1;
      push(f, S_FILT, m_retry);
      push(f + LF, S_HOLD, m_retry);
      run_edge = f + LF + RH;
      if (to_run) begin
         m_retry = 0;
         push(run_edge, S_RUN, 0);
      end
   endtask

   // Monitor: every change of state/outputs must match the next queued entry.
   initial begin
      ev_t e;
      logic [RW+6:0] prev;
      logic [RW+6:0] expv;
      wait (cyc >= 3);
      @(negedge clk);
      prev = act;
      forever begin
         @(negedge clk);
         while (q.size() > 0 && q[0].cyc < cyc) begin
            checks++;
            failures++;
            $display("FAIL missed_event: got no change, required state %0d at cycle %0d (now %0d)",
                     q[0].st, q[0].cyc, cyc);
            void'(q.pop_front());
         end
         if (act !== prev) begin
            checks++;
            if (q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_change: got %b at cycle %0d, required no change", act, cyc);
            end else begin
               e = q.pop_front();
               expv = exp_tuple(e.st, int'(e.rt));
               if (e.cyc != cyc || act !== expv) begin
                  failures++;
                  $display("FAIL event: got %b at cycle %0d, required %b at cycle %0d",
                           act, cyc, expv, e.cyc);
               end
            end
            prev = act;
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: time budget exceeded at cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   // Stimulus and expectation generation.
   initial begin
      int r, e, e2, e3, e4, h, g, d, s, x, sf, run, run2, run3;
      bus.locked_i = 1'b0;
      bus.soft_rst_req_i = 1'b0;
      last_st = S_MMCM;
      last_rt = 0;
      repeat (3) @(negedge clk);
      checks++;
      if (act !== exp_tuple(S_MMCM, 0)) begin
         failures++;
         $display("FAIL reset_state: got %b, required %b", act, exp_tuple(S_MMCM, 0));
      end
      @(negedge clk);

      // Nominal lock, first pass exactly on the timeout edge; soft requests ignored.
      for (int i = 0; i < 5; i++) begin
         do_reset(r);
         push(r + M, S_WAIT, 0);
         e = (i == 0) ? r + M + T - 2 : r + int'($urandom_range(1, M + T - 2));
         exp_climb(r + M, e, 1'b1, run);
         sf = r + int'($urandom_range(1, run - r - 1));
         drive(run + 3, e, INF, sf, NO);
      end

      // Lock one edge too late: one retry, then lock on the second attempt.
      do_reset(r);
      push(r + M, S_WAIT, 0);
      push(r + M + T, S_MMCM, 1);
      m_retry = 1;
      push(r + 2 * M + T, S_WAIT, 1);
      e = r + M + T - 1;
      exp_climb(r + 2 * M + T, e, 1'b1, run);
      drive(run + 3, e, INF, NO, NO);

      // Lock glitches of 1..LF high edges fall back to waiting, then stable lock.
      for (int i = 0; i < 4; i++) begin
         do_reset(r);
         push(r + M, S_WAIT, 0);
         e = r + M - 1 + int'($urandom_range(0, 9));
         h = (i == 0) ? LF : int'($urandom_range(1, LF));
         g = int'($urandom_range(1, 8));
         push(e + 2, S_FILT, 0);
         push(e + 2 + h, S_WAIT, 0);
         e2 = e + h + g;
         exp_climb(e + 2 + h, e2, 1'b1, run);
         drive(e2 - 1, e, e + h, NO, NO);
         drive(run + 3, e2, INF, NO, NO);
      end

      // RUN: soft reset (second pulse lands in HOLD), lock loss, and both together.
      do_reset(r);
      push(r + M, S_WAIT, 0);
      e = r + M + 1;
      exp_climb(r + M, e, 1'b1, run);
      drive(run + 2, e, INF, NO, NO);
      s = cyc + 2;
      push(s, S_HOLD, 0);
      push(s + RH, S_RUN, 0);
      drive(s + RH + 3, e, INF, s, s + 2);
      d = cyc + 1 + int'($urandom_range(0, 3));
      push(d + 2, S_MMCM, 0);
      push(d + 2 + M, S_WAIT, 0);
      e3 = d + int'($urandom_range(1, 15));
      exp_climb(d + 2 + M, e3, 1'b1, run2);
      drive(e3 - 1, e, d, NO, NO);
      drive(run2 + 3, e3, INF, NO, NO);
      d = cyc + 2;
      push(d + 2, S_MMCM, 0);
      push(d + 2 + M, S_WAIT, 0);
      e4 = d + 5;
      exp_climb(d + 2 + M, e4, 1'b1, run3);
      drive(e4 - 1, e3, d, d + 2, NO);
      drive(run3 + 3, e4, INF, NO, NO);

      // Reset asserted while holding the system reset.
      do_reset(r);
      push(r + M, S_WAIT, 0);
      e = r + int'($urandom_range(1, M + T - 2));
      exp_climb(r + M, e, 1'b0, run);
      x = run - RH + int'($urandom_range(1, RH - 1));
      drive(x - 1, e, INF, NO, NO);
      do_reset(r);

      // Never lock: three attempts then sticky FAIL; later lock/soft ignored.
      do_reset(r);
      push(r + M, S_WAIT, 0);
      for (int a = 1; a <= MR; a++) begin
         push(r + a * (M + T), S_MMCM, a);
         push(r + a * (M + T) + M, S_WAIT, a);
      end
      push(r + (MR + 1) * (M + T), S_FAIL, MR);
      drive(r + (MR + 1) * (M + T) + 5, INF, INF, NO, NO);
      drive(cyc + 25, cyc + 1, INF, cyc + 6, cyc + 12);

      // Reset out of FAIL, then a final nominal climb.
      do_reset(r);
      push(r + M, S_WAIT, 0);
      e = r + M + 2;
      exp_climb(r + M, e, 1'b1, run);
      drive(run + 4, e, INF, NO, NO);

      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d pending expected events, required 0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/rvlab_clk_rst_seq.md
Name: rvlab_clk_rst_seq

Overview:
Power-up and recovery sequencer for the system MMCM and the system reset.
- Pulses the MMCM reset and waits for LOCKED with a timeout and bounded retries.
- Debounces lock, then holds the system reset request for a fixed time before releasing it.
- Runs on the free-running buffered 100 MHz input clock, so it keeps working while sys_clk is gated.
- Sits beside the clock manager in the FPGA top.

Parameters:
- MMCM_RST_CYCLES, 16: cycles mmcm_rst_o is held high per attempt.
- LOCK_TIMEOUT_CYCLES, 100000: cycles to wait for lock per attempt (1 ms).
- LOCK_FILTER_CYCLES, 8: consecutive synchronized-lock-high cycles required before lock is accepted.
- RST_HOLD_CYCLES, 64: cycles sys_rst_req_o stays high after lock is accepted.
- MAX_RETRIES, 3: extra MMCM reset attempts after the first timeout before failing.

Ports:
- clk_100mhz_i  in  1  buffered free-running 100 MHz clock.
- rst_i  in  1  synchronous, active-high reset.
- locked_i  in  1  MMCM LOCKED; asynchronous, synchronized internally by 2 flops.
- soft_rst_req_i  in  1  single-cycle request to re-run the system reset hold without resetting the MMCM.
- mmcm_rst_o  out  1  drives MMCM RST.
- sys_rst_req_o  out  1  system reset request, active high; the consumer synchronizes it.
- ready_o  out  1  clock locked and system out of reset.
- fail_o  out  1  lock never achieved; sticky.
- retry_cnt_o  out  $clog2(MAX_RETRIES+1)  timeout retries consumed in the current sequence.
- state_o  out  3  state encoding, for debug.

Behaviour:
General:
- One clock domain: clk_100mhz_i. rst_i is synchronous, active-high.
- Every output is a registered decode of the state and counters; no combinational paths from inputs to outputs.
- One cycle counter cnt is shared by all states and cleared on every state transition.
- lock_s is the 2-flop-synchronized locked_i.

Reset values (rst_i high):
- state = S_MMCM_RST, cnt = 0, retry = 0, sync flops = 0.
- mmcm_rst_o = 1, sys_rst_req_o = 1, ready_o = 0, fail_o = 0.

States:
- S_MMCM_RST (0)
  - mmcm_rst_o = 1, sys_rst_req_o = 1.
  - When cnt == MMCM_RST_CYCLES-1, go to S_WAIT_LOCK.
  - mmcm_rst_o is high for exactly MMCM_RST_CYCLES cycles after rst_i deasserts.
- S_WAIT_LOCK (1)
  - mmcm_rst_o = 0.
  - If lock_s = 1, go to S_LOCK_FILTER.
  - Else, at cnt == LOCK_TIMEOUT_CYCLES-1:
    - if retry == MAX_RETRIES, go to S_FAIL;
    - otherwise retry++ and go to S_MMCM_RST.
  - If lock_s rises in the same cycle as the timeout, lock wins.
- S_LOCK_FILTER (2)
  - If lock_s = 0, return to S_WAIT_LOCK; the timeout restarts from 0 and retry is unchanged.
  - If cnt == LOCK_FILTER_CYCLES-1 and lock_s = 1, go to S_RST_HOLD.
- S_RST_HOLD (3)
  - sys_rst_req_o = 1.
  - If lock_s = 0, go to S_WAIT_LOCK.
  - Else, at cnt == RST_HOLD_CYCLES-1, go to S_RUN.
- S_RUN (4)
  - sys_rst_req_o = 0, ready_o = 1, retry is cleared to 0.
  - If lock_s = 0, go to S_MMCM_RST (full re-lock).
  - Else if soft_rst_req_i = 1, go to S_RST_HOLD.
  - Lock loss has priority over soft_rst_req_i when both occur in the same cycle.
- S_FAIL (5)
  - mmcm_rst_o = 0, sys_rst_req_o = 1, fail_o = 1.
  - Terminal; only rst_i exits this state.

Timing and boundaries:
- soft_rst_req_i is ignored in every state except S_RUN.
- Latency from locked_i sampled high at edge E (while in S_WAIT_LOCK) to ready_o high: edge E + 2 + LOCK_FILTER_CYCLES + RST_HOLD_CYCLES.
- cnt width is sized for the largest parameter; cnt never wraps, because every terminal count forces a transition.
- All parameters must be >= 1.
- rst_i asserted in any state returns the block to the reset values on the next edge.

Test Plan:
Bench parameters: MMCM_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, LOCK_FILTER_CYCLES=3, RST_HOLD_CYCLES=5, MAX_RETRIES=2.

1. Nominal: deassert rst_i; raise locked_i 10 cycles later and hold it.
   -> mmcm_rst_o high exactly 4 cycles; ready_o rises 10 cycles after locked_i is sampled; sys_rst_req_o falls on the same edge; retry_cnt_o = 0.
2. Never lock: locked_i held at 0.
   -> mmcm_rst_o pulses 3 times (4 cycles each); fail_o rises 72 cycles after rst_i deasserts; retry_cnt_o = 2; sys_rst_req_o stays 1; a subsequent locked_i = 1 is ignored.
3. Lock glitch: locked_i high 2 cycles, low, then high and stable.
   -> LOCK_FILTER returns to WAIT_LOCK; ready_o rises 10 cycles after the second rise; retry_cnt_o = 0.
4. Lock loss in RUN: drop locked_i.
   -> 2 cycles later state = S_MMCM_RST, mmcm_rst_o = 1, ready_o = 0, sys_rst_req_o = 1; re-lock gives ready_o again.
5. Soft reset: 1-cycle soft_rst_req_i in RUN.
   -> sys_rst_req_o high exactly 5 cycles, mmcm_rst_o stays 0.
   Same pulse during RST_HOLD has no effect. Same pulse coincident with lock loss -> S_MMCM_RST.
6. Reset mid-operation: assert rst_i during S_RST_HOLD and during S_FAIL.
   -> next edge: all outputs at reset values, fail_o = 0, retry_cnt_o = 0.
